// File: rtl/lab7_soc_edge_pio.sv
// ============================================================================
// lab7_soc_edge_pio
// Avalon-MM input PIO with synchroniser, optional per-bit debounce filter,
// sticky edge capture and a maskable level interrupt.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   reset      asynchronous, active-high reset
//   address    register word select (0 DATA, 1 IRQ_MASK, 2 reserved,
//              3 EDGE_CAPTURE write-1-to-clear)
//   chipselect slave select, qualifies writes
//   write_n    active-low write strobe
//   writedata  write data (bits at and above WIDTH are ignored)
//   in_port    asynchronous external inputs
//   readdata   registered read data, one cycle latency
//   irq        |(EDGE_CAPTURE & IRQ_MASK)
// ============================================================================
module lab7_soc_edge_pio #(
    parameter int unsigned WIDTH           = 16,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 0,
    parameter int unsigned EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_sel_e;

    localparam edge_sel_e EDGE_SEL = edge_sel_e'(EDGE_TYPE[1:0]);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] f_q;
    logic [WIDTH-1:0] f_d_q;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] cap_q;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] cap_clr;
    logic [31:0]      rd_mux;
    logic             wr_en;

    // ------------------------------------------------------------------
    // Synchroniser chain
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= in_port;
            for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Debounce filter
    // ------------------------------------------------------------------
    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_no_filter
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    f_q <= '0;
                end else begin
                    f_q <= s;
                end
            end
        end else begin : g_filter
            localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
            localparam logic [CW-1:0] CNT_ONE  = CW'(1);

            logic [CW-1:0] cnt_q [WIDTH];

            // The counter measures how long s has disagreed with f; any
            // agreement (i.e. a bounce back) restarts it from zero.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    f_q <= '0;
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        cnt_q[i] <= '0;
                    end
                end else begin
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        if (s[i] == f_q[i]) begin
                            cnt_q[i] <= '0;
                        end else if (cnt_q[i] == CNT_LAST) begin
                            f_q[i]   <= s[i];
                            cnt_q[i] <= '0;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + CNT_ONE;
                        end
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_d_q <= '0;
        end else begin
            f_d_q <= f_q;
        end
    end

    always_comb begin
        evt = '0;
        case (EDGE_SEL)
            EDGE_RISE: evt = f_q & ~f_d_q;
            EDGE_FALL: evt = ~f_q & f_d_q;
            default:   evt = f_q ^ f_d_q;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus registers
    // ------------------------------------------------------------------
    assign wr_en   = chipselect & ~write_n;
    assign wdata   = writedata[WIDTH-1:0];
    assign cap_clr = (wr_en && address == 2'd3) ? wdata : '0;

    generate
        if (WIDTH < 32) begin : g_wdata_upper
            logic unused_wdata_upper;
            assign unused_wdata_upper = ^writedata[31:WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask_q <= '0;
            cap_q  <= '0;
        end else begin
            if (wr_en && address == 2'd1) begin
                mask_q <= wdata;
            end
            // OR-ing the event after the clear makes a simultaneous set win.
            cap_q <= (cap_q & ~cap_clr) | evt;
        end
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0:    rd_mux[WIDTH-1:0] = f_q;
            2'd1:    rd_mux[WIDTH-1:0] = mask_q;
            2'd3:    rd_mux[WIDTH-1:0] = cap_q;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

    assign irq = |(cap_q & mask_q);

endmodule

// File: tb/tb_lab7_soc_edge_pio.sv
// ============================================================================
// tb_lab7_soc_edge_pio
// Self-checking bench for lab7_soc_edge_pio. Three instances share the bus:
//   u_dut : WIDTH 16, no debounce, rising edges
//   u_deb : WIDTH 16, DEBOUNCE_CYCLES 8, rising edges
//   u_any : WIDTH 32, no debounce, any edge
// ============================================================================
module tb_lab7_soc_edge_pio;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [15:0] in_dut;
    logic [15:0] in_deb;
    logic [31:0] in_any;
    logic [31:0] rd_dut, rd_deb, rd_any;
    logic        irq_dut, irq_deb, irq_any;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lab7_soc_edge_pio #(.WIDTH(16), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(0)) u_dut (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_dut),
        .readdata(rd_dut), .irq(irq_dut)
    );

    lab7_soc_edge_pio #(.WIDTH(16), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .EDGE_TYPE(0)) u_deb (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_deb),
        .readdata(rd_deb), .irq(irq_deb)
    );

    lab7_soc_edge_pio #(.WIDTH(32), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0), .EDGE_TYPE(2)) u_any (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_any),
        .readdata(rd_any), .irq(irq_any)
    );

    typedef struct {
        logic [15:0] pin;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs [22];

    function automatic vec_t mk(logic [15:0] pin, logic wr, logic [1:0] addr,
                                logic [31:0] wdata, logic [31:0] exp_rd, logic exp_irq);
        vec_t v;
        v.pin = pin; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.exp_rd = exp_rd; v.exp_irq = exp_irq;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write_n   = 1'b0;
        tick();
        write_n   = 1'b1;
    endtask

    initial begin
        // in_dut, wr, addr, wdata, expected readdata, expected irq
        vecs[0]  = mk(16'h00A5, 1'b0, 2'd0, 32'h0,      32'h0,  1'b0);
        vecs[1]  = mk(16'h00A5, 1'b0, 2'd1, 32'h0,      32'h0,  1'b0);
        vecs[2]  = mk(16'h00A5, 1'b0, 2'd3, 32'h0,      32'h0,  1'b0);
        vecs[3]  = mk(16'h00A5, 1'b0, 2'd0, 32'h0,      32'hA5, 1'b0);
        vecs[4]  = mk(16'h00A5, 1'b0, 2'd2, 32'h0,      32'h0,  1'b0);
        vecs[5]  = mk(16'h00A5, 1'b0, 2'd3, 32'h0,      32'hA5, 1'b0);
        vecs[6]  = mk(16'h00A5, 1'b1, 2'd3, 32'hFFFF,   32'hA5, 1'b0);
        vecs[7]  = mk(16'h0000, 1'b1, 2'd1, 32'h0001,   32'h0,  1'b0);
        vecs[8]  = mk(16'h0000, 1'b0, 2'd1, 32'h0,      32'h1,  1'b0);
        vecs[9]  = mk(16'h0000, 1'b0, 2'd3, 32'h0,      32'h0,  1'b0);
        vecs[10] = mk(16'h0000, 1'b0, 2'd3, 32'h0,      32'h0,  1'b0);
        vecs[11] = mk(16'h0001, 1'b0, 2'd3, 32'h0,      32'h0,  1'b0);
        vecs[12] = mk(16'h0001, 1'b0, 2'd3, 32'h0,      32'h0,  1'b0);
        vecs[13] = mk(16'h0001, 1'b0, 2'd3, 32'h0,      32'h0,  1'b0);
        vecs[14] = mk(16'h0001, 1'b0, 2'd3, 32'h0,      32'h0,  1'b1);
        vecs[15] = mk(16'h0001, 1'b0, 2'd3, 32'h0,      32'h1,  1'b1);
        vecs[16] = mk(16'h0000, 1'b0, 2'd3, 32'h0,      32'h1,  1'b1);
        vecs[17] = mk(16'h0000, 1'b0, 2'd3, 32'h0,      32'h1,  1'b1);
        vecs[18] = mk(16'h0000, 1'b0, 2'd3, 32'h0,      32'h1,  1'b1);
        vecs[19] = mk(16'h0000, 1'b0, 2'd3, 32'h0,      32'h1,  1'b1);
        vecs[20] = mk(16'h0000, 1'b1, 2'd3, 32'h0001,   32'h1,  1'b0);
        vecs[21] = mk(16'h0000, 1'b0, 2'd3, 32'h0,      32'h0,  1'b0);

        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b1;
        write_n    = 1'b1;
        writedata  = 32'h0;
        in_dut     = 16'h0;
        in_deb     = 16'h0;
        in_any     = 32'h0;
        tick();
        tick();
        chk("reset rd_dut", rd_dut, 32'h0);
        chk("reset irq_dut", {31'h0, irq_dut}, 32'h0);
        chk("reset rd_any", rd_any, 32'h0);
        reset = 1'b0;

        // ---------------- table-driven basic sequence on u_dut ----------
        for (int i = 0; i < 22; i++) begin
            in_dut    = vecs[i].pin;
            write_n   = ~vecs[i].wr;
            address   = vecs[i].addr;
            writedata = vecs[i].wdata;
            tick();
            chk($sformatf("vec%0d readdata", i), rd_dut, vecs[i].exp_rd);
            chk($sformatf("vec%0d irq", i), {31'h0, irq_dut}, {31'h0, vecs[i].exp_irq});
        end
        write_n = 1'b1;

        // ---------------- set/clear collision --------------------------
        address = 2'd3;
        in_dut  = 16'h0002;
        repeat (4) tick();
        in_dut = 16'h0003;
        repeat (3) tick();
        writedata = 32'h3;
        write_n   = 1'b0;
        tick();
        write_n = 1'b1;
        chk("collision old cap", rd_dut, 32'h2);
        chk("collision irq", {31'h0, irq_dut}, 32'h1);
        tick();
        chk("collision cap", rd_dut, 32'h1);

        // ---------------- debounce: 5-cycle glitch ----------------------
        address = 2'd0;
        in_deb  = 16'h0008;
        for (int k = 1; k <= 16; k++) begin
            if (k == 6) in_deb = 16'h0000;
            tick();
            chk($sformatf("glitch data k%0d", k), rd_deb, 32'h0);
        end
        address = 2'd3;
        tick();
        tick();
        chk("glitch cap", rd_deb, 32'h0);
        chk("glitch irq", {31'h0, irq_deb}, 32'h0);

        // ---------------- debounce: 20-cycle high -----------------------
        address = 2'd0;
        in_deb  = 16'h0008;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k >= 9 && k <= 13)
                chk($sformatf("debounce data k%0d", k), rd_deb, (k >= 11) ? 32'h8 : 32'h0);
        end
        in_deb = 16'h0000;
        repeat (12) tick();
        address = 2'd3;
        tick();
        chk("debounce cap", rd_deb, 32'h8);

        // ---------------- reset mid-debounce / mid-capture --------------
        in_deb = 16'h000F;
        repeat (12) tick();
        in_deb = 16'h0000;
        repeat (12) tick();
        chk("pre-reset cap", rd_deb, 32'hF);
        in_deb = 16'h0008;
        repeat (8) tick();
        reset = 1'b1;
        #1;
        chk("mid reset rd_deb", rd_deb, 32'h0);
        chk("mid reset irq_deb", {31'h0, irq_deb}, 32'h0);
        chk("mid reset rd_dut", rd_dut, 32'h0);
        chk("mid reset irq_dut", {31'h0, irq_dut}, 32'h0);
        @(posedge clk);
        #1;
        reset   = 1'b0;
        address = 2'd1;
        tick();
        chk("post reset mask", rd_deb, 32'h0);
        address = 2'd3;
        tick();
        chk("post reset cap", rd_deb, 32'h0);
        address = 2'd0;
        for (int k = 3; k <= 11; k++) begin
            tick();
            if (k >= 9)
                chk($sformatf("restart data k%0d", k), rd_deb, (k >= 11) ? 32'h8 : 32'h0);
        end

        // ---------------- any-edge, WIDTH 32, bit31 ---------------------
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_write(2'd3, 32'hFFFF_FFFF);
        address = 2'd3;
        tick();
        chk("any idle irq", {31'h0, irq_any}, 32'h0);
        in_any = 32'h8000_0000;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("any rise irq k%0d", k), {31'h0, irq_any}, (k >= 4) ? 32'h1 : 32'h0);
            if (k == 5) chk("any rise cap", rd_any, 32'h8000_0000);
        end
        bus_write(2'd3, 32'h8000_0000);
        chk("any clear irq", {31'h0, irq_any}, 32'h0);
        address = 2'd2;
        in_any  = 32'h0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("any reserved k%0d", k), rd_any, 32'h0);
            chk($sformatf("any fall irq k%0d", k), {31'h0, irq_any}, (k >= 4) ? 32'h1 : 32'h0);
        end
        address = 2'd3;
        tick();
        chk("any fall cap", rd_any, 32'h8000_0000);
        bus_write(2'd2, 32'hFFFF_FFFF);
        address = 2'd2;
        tick();
        chk("reserved after write", rd_any, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
